// File: rtl/board_scan_reader.sv
// board_scan_reader: walks the 10x10 game-board RAM once per frame-start pulse,
// one read outstanding, and streams each cell to the renderer over valid/ready.
// Ports: clk, rst_n (async, active-low), start, busy, mem_read/mem_address/mem_out
// (RAM read port), cell_valid/cell_ready/cell_data/cell_row/cell_col/cell_last,
// frame_done. Optional macro CELL_RANGE_CHECK_EN adds range_err (sticky flag for
// board words with nonzero bits above CELL_W; such cells are sent as all-ones).
module board_scan_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h1000,
  parameter int ROWS   = 10,
  parameter int COLS   = 10,
  parameter int CELL_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              mem_read,
  output logic [31:0]       mem_address,
  input  logic [31:0]       mem_out,
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic [CELL_W-1:0] cell_data,
  output logic [3:0]        cell_row,
  output logic [3:0]        cell_col,
  output logic              cell_last,
`ifdef CELL_RANGE_CHECK_EN
  output logic              range_err,
`endif
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, SEND, DONE
  } state_t;

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] WMAX = LW'(RD_LAT - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
  localparam logic [3:0] COL_MAX = 4'(COLS - 1);

  state_t      state;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] off;
  logic [LW-1:0] wcnt;
  logic        last_cell;
  logic [CELL_W-1:0] cap;

  assign last_cell = (row == ROW_MAX) && (col == COL_MAX);

`ifdef CELL_RANGE_CHECK_EN
  logic hi_bad;
  assign hi_bad = |mem_out[31:CELL_W];
  assign cap = hi_bad ? '1 : mem_out[CELL_W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^mem_out[31:CELL_W];
  assign cap = mem_out[CELL_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= BASE_ADDR;
      cell_valid  <= 1'b0;
      cell_data   <= '0;
      cell_row    <= '0;
      cell_col    <= '0;
      cell_last   <= 1'b0;
      frame_done  <= 1'b0;
      row         <= '0;
      col         <= '0;
      off         <= '0;
      wcnt        <= '0;
`ifdef CELL_RANGE_CHECK_EN
      range_err   <= 1'b0;
`endif
    end else begin
      mem_read   <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            mem_read    <= 1'b1;
            mem_address <= BASE_ADDR + off;
`ifdef CELL_RANGE_CHECK_EN
            range_err   <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          if (wcnt == WMAX) begin
            state      <= SEND;
            cell_valid <= 1'b1;
            cell_data  <= cap;
            cell_row   <= row;
            cell_col   <= col;
            cell_last  <= last_cell;
`ifdef CELL_RANGE_CHECK_EN
            if (hi_bad) range_err <= 1'b1;
`endif
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        SEND: begin
          if (cell_ready) begin
            cell_valid <= 1'b0;
            cell_last  <= 1'b0;
            if (last_cell) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              // next read is issued in the same edge to keep 3-cycle cadence
              state       <= ISSUE;
              mem_read    <= 1'b1;
              mem_address <= BASE_ADDR + off + 32'd4;
              off         <= off + 32'd4;
              if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          row   <= '0;
          col   <= '0;
          off   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scan_reader.sv
// Directed bench for board_scan_reader: two instances (RD_LAT=1 and 3)
// share a board RAM model with a latency pipeline that only yields data on time.
module tb_board_scan_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic sel3 = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:127];

  logic start1, start3, rdy1, rdy3;
  assign start1 = start & ~sel3;
  assign start3 = start & sel3;
  assign rdy1 = ready | sel3;
  assign rdy3 = ready | ~sel3;

  logic busy1, mr1, cv1, last1, fd1, re1;
  logic busy3, mr3, cv3, last3, fd3, re3;
  logic [31:0] ma1, ma3, mo1, mo3;
  logic [3:0] cd1, cd3, row1, row3, col1, col3;

  board_scan_reader dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
    .mem_read(mr1), .mem_address(ma1), .mem_out(mo1),
    .cell_valid(cv1), .cell_ready(rdy1), .cell_data(cd1),
    .cell_row(row1), .cell_col(col1), .cell_last(last1),
`ifdef CELL_RANGE_CHECK_EN
    .range_err(re1),
`endif
    .frame_done(fd1)
  );

  board_scan_reader #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3),
    .mem_read(mr3), .mem_address(ma3), .mem_out(mo3),
    .cell_valid(cv3), .cell_ready(rdy3), .cell_data(cd3),
    .cell_row(row3), .cell_col(col3), .cell_last(last3),
`ifdef CELL_RANGE_CHECK_EN
    .range_err(re3),
`endif
    .frame_done(fd3)
  );

`ifndef CELL_RANGE_CHECK_EN
  assign re1 = 1'b0;
  assign re3 = 1'b0;
`endif

  // RAM model: data appears exactly RD_LAT cycles after mem_read, garbage otherwise
  logic [31:0] rd1, rd3, d1, d3;
  always_comb begin
    d1 = ma1 - 32'h1000;
    d3 = ma3 - 32'h1000;
    rd1 = 32'hA5A5_A5A5;
    rd3 = 32'hA5A5_A5A5;
    if (ma1 >= 32'h1000 && ma1 < 32'h1190) rd1 = ram[d1[8:2]];
    if (ma3 >= 32'h1000 && ma3 < 32'h1190) rd3 = ram[d3[8:2]];
  end

  logic [32:0] p1;
  logic [32:0] p3 [0:2];
  always_ff @(posedge clk) begin
    p1    <= {mr1, rd1};
    p3[0] <= {mr3, rd3};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mo1 = p1[32] ? p1[31:0] : 32'hA5A5_A5A5;
  assign mo3 = p3[2][32] ? p3[2][31:0] : 32'hA5A5_A5A5;

  logic o_busy, o_mr, o_v, o_last, o_fd, o_re;
  logic [31:0] o_ma;
  logic [3:0] o_d, o_row, o_col;
  always_comb begin
    o_busy = sel3 ? busy3 : busy1;
    o_mr   = sel3 ? mr3 : mr1;
    o_ma   = sel3 ? ma3 : ma1;
    o_v    = sel3 ? cv3 : cv1;
    o_d    = sel3 ? cd3 : cd1;
    o_row  = sel3 ? row3 : row1;
    o_col  = sel3 ? col3 : col1;
    o_last = sel3 ? last3 : last1;
    o_fd   = sel3 ? fd3 : fd1;
    o_re   = sel3 ? re3 : re1;
  end

  int errors = 0;
  int checks = 0;

  // observations of one run
  logic [3:0] g_d [0:127];
  logic [3:0] g_row [0:127];
  logic [3:0] g_col [0:127];
  logic g_last [0:127];
  logic g_re [0:127];
  logic busy_at [0:1023];
  int n_cells, n_reads, addr_bad, multi_read, n_done, done_cyc, last_hs;
  int st_cnt, st_reads;
  logic st_stable;
  logic [31:0] first_addr, ab_addr;
  logic ab_any;
  logic [15:0] snap;

  task automatic run_frame(input int stall_cell, input int stall_len,
                           input int sa, input int sb,
                           input int abort_cell, input int max_cyc);
    int st_left;
    logic prev_mr;
    n_cells = 0; n_reads = 0; addr_bad = 0; multi_read = 0;
    n_done = 0; done_cyc = 0; last_hs = 0; st_cnt = 0; st_reads = 0;
    st_stable = 1'b1; first_addr = 32'hFFFF_FFFF; ab_any = 1'b1;
    ab_addr = 32'hFFFF_FFFF; st_left = stall_len; prev_mr = 1'b0;
    snap = '0;
    for (int k = 0; k < 1024; k++) busy_at[k] = 1'bx;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      busy_at[c] = o_busy;
      if (o_mr) begin
        if (o_ma !== 32'h1000 + 32'(4 * n_reads)) addr_bad++;
        if (n_reads == 0) first_addr = o_ma;
        n_reads++;
        if (prev_mr) multi_read++;
      end
      prev_mr = o_mr;
      if (o_fd) begin
        n_done++;
        done_cyc = c;
      end
      start = (c == sa) || (c == sb);
      if (abort_cell >= 0 && o_v && n_cells == abort_cell) begin
        rst_n = 1'b0;
        #1;
        ab_any = o_v | o_busy | o_mr | o_last | o_fd | o_re |
                 (|o_d) | (|o_row) | (|o_col);
        ab_addr = o_ma;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (o_v && n_cells == stall_cell && st_left > 0) begin
        ready = 1'b0;
        if (st_cnt == 0) snap = {o_d, o_row, o_col, o_last, o_v, 2'b00};
        else if (snap !== {o_d, o_row, o_col, o_last, o_v, 2'b00})
          st_stable = 1'b0;
        st_cnt++;
        st_left--;
        if (o_mr) st_reads++;
      end else begin
        if (st_cnt > 0 && o_v && n_cells == stall_cell &&
            snap !== {o_d, o_row, o_col, o_last, o_v, 2'b00})
          st_stable = 1'b0;
        ready = 1'b1;
      end
      if (o_v && ready && n_cells < 128) begin
        g_d[n_cells]   = o_d;
        g_row[n_cells] = o_row;
        g_col[n_cells] = o_col;
        g_last[n_cells] = o_last;
        g_re[n_cells]  = o_re;
        n_cells++;
        last_hs = c;
      end
      if (n_done > 0 && c == done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    sel3 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, mr1, cv1, last1, fd1, re1, cd1, row1, col1} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%0h want=0",
               {busy1, mr1, cv1, last1, fd1, re1, cd1, row1, col1});
    end
    checks++;
    if (ma1 !== 32'h1000) begin
      errors++;
      $display("FAIL reset_addr got=%0h want=1000", ma1);
    end
    checks++;
    if ({busy3, mr3, cv3, fd3} !== 4'd0 || ma3 !== 32'h1000) begin
      errors++;
      $display("FAIL reset_lat3 got=%0h/%0h want=0/1000",
               {busy3, mr3, cv3, fd3}, ma3);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    run_frame(-1, 0, -1, -1, -1, 400);
    checks++;
    if (n_cells !== 100) begin
      errors++;
      $display("FAIL frame_cells got=%0d want=100", n_cells);
    end
    for (int i = 0; i < 100 && i < n_cells; i++) begin
      checks++;
      if (g_d[i] !== i[3:0] || g_row[i] !== 4'(i / 10) ||
          g_col[i] !== 4'(i % 10) || g_last[i] !== (i == 99)) begin
        errors++;
        $display("FAIL frame_cell%0d got=%0h,%0d,%0d,%0b want=%0h,%0d,%0d,%0b",
                 i, g_d[i], g_row[i], g_col[i], g_last[i],
                 i[3:0], i / 10, i % 10, i == 99);
      end
    end
    checks++;
    if (n_done !== 1 || done_cyc !== 301 || last_hs !== 300) begin
      errors++;
      $display("FAIL frame_timing got=%0d/%0d/%0d want=1/301/300",
               n_done, done_cyc, last_hs);
    end
    checks++;
    if (busy_at[1] !== 1'b1 || busy_at[301] !== 1'b1 ||
        busy_at[302] !== 1'b0) begin
      errors++;
      $display("FAIL frame_busy got=%b%b%b want=110",
               busy_at[1], busy_at[301], busy_at[302]);
    end
    checks++;
    if (n_reads !== 100 || addr_bad !== 0 || multi_read !== 0) begin
      errors++;
      $display("FAIL frame_reads got=%0d/%0d/%0d want=100/0/0",
               n_reads, addr_bad, multi_read);
    end
  endtask

  task automatic test_stall();
    run_frame(37, 5, -1, -1, -1, 400);
    checks++;
    if (st_cnt !== 5 || st_stable !== 1'b1 || st_reads !== 0) begin
      errors++;
      $display("FAIL stall_hold got=%0d/%0b/%0d want=5/1/0",
               st_cnt, st_stable, st_reads);
    end
    checks++;
    if (g_row[37] !== 4'd3 || g_col[37] !== 4'd7 ||
        g_row[38] !== 4'd3 || g_col[38] !== 4'd8 || g_d[38] !== 4'd6) begin
      errors++;
      $display("FAIL stall_resume got=(%0d,%0d) (%0d,%0d) d=%0h want=(3,7) (3,8) d=6",
               g_row[37], g_col[37], g_row[38], g_col[38], g_d[38]);
    end
    checks++;
    if (n_cells !== 100 || n_done !== 1 || done_cyc !== 306) begin
      errors++;
      $display("FAIL stall_frame got=%0d/%0d/%0d want=100/1/306",
               n_cells, n_done, done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    run_frame(-1, 0, 10, 50, -1, 400);
    checks++;
    if (n_cells !== 100 || n_done !== 1 || n_reads !== 100) begin
      errors++;
      $display("FAIL start_ignored got=%0d/%0d/%0d want=100/1/100",
               n_cells, n_done, n_reads);
    end
    checks++;
    if (done_cyc !== 301 || busy_at[304] !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_tail got=%0d/%b want=301/0",
               done_cyc, busy_at[304]);
    end
  endtask

  task automatic test_reset_midframe();
    run_frame(-1, 0, -1, -1, 52, 400);
    checks++;
    if (ab_any !== 1'b0 || ab_addr !== 32'h1000) begin
      errors++;
      $display("FAIL abort_outputs got=%b/%0h want=0/1000", ab_any, ab_addr);
    end
    checks++;
    if (n_done !== 0 || n_cells !== 52) begin
      errors++;
      $display("FAIL abort_no_done got=%0d/%0d want=0/52", n_done, n_cells);
    end
    repeat (3) @(negedge clk);
    run_frame(-1, 0, -1, -1, -1, 400);
    checks++;
    if (first_addr !== 32'h1000 || g_row[0] !== 4'd0 ||
        g_col[0] !== 4'd0 || n_cells !== 100 || n_done !== 1) begin
      errors++;
      $display("FAIL abort_restart got=%0h (%0d,%0d) %0d %0d want=1000 (0,0) 100 1",
               first_addr, g_row[0], g_col[0], n_cells, n_done);
    end
  endtask

  task automatic test_latency3();
    int bad;
    sel3 = 1'b1;
    bad = 0;
    run_frame(-1, 0, -1, -1, -1, 700);
    for (int i = 0; i < 100 && i < n_cells; i++) begin
      checks++;
      if (g_d[i] !== i[3:0] || g_row[i] !== 4'(i / 10) ||
          g_col[i] !== 4'(i % 10)) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL lat3_cell%0d got=%0h want=%0h", i, g_d[i], i[3:0]);
      end
    end
    checks++;
    if (n_cells !== 100 || done_cyc !== 501 || last_hs !== 500) begin
      errors++;
      $display("FAIL lat3_timing got=%0d/%0d/%0d want=100/501/500",
               n_cells, done_cyc, last_hs);
    end
    checks++;
    if (n_reads !== 100 || multi_read !== 0 || addr_bad !== 0) begin
      errors++;
      $display("FAIL lat3_reads got=%0d/%0d/%0d want=100/0/0",
               n_reads, multi_read, addr_bad);
    end
    sel3 = 1'b0;
  endtask

  task automatic test_range();
    ram[4] = 32'h0000_0012;
    run_frame(-1, 0, -1, -1, -1, 400);
`ifdef CELL_RANGE_CHECK_EN
    checks++;
    if (g_d[4] !== 4'hF || g_d[5] !== 4'h5 || g_re[3] !== 1'b0 ||
        g_re[4] !== 1'b1 || g_re[99] !== 1'b1) begin
      errors++;
      $display("FAIL range_flag got=%0h %0h %b%b%b want=f 5 011",
               g_d[4], g_d[5], g_re[3], g_re[4], g_re[99]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (re1 !== 1'b1) begin
      errors++;
      $display("FAIL range_sticky got=%b want=1", re1);
    end
    ram[4] = 32'd4;
    run_frame(-1, 0, -1, -1, -1, 400);
    checks++;
    if (g_re[0] !== 1'b0 || re1 !== 1'b0 || g_d[4] !== 4'd4) begin
      errors++;
      $display("FAIL range_clear got=%b %b %0h want=0 0 4",
               g_re[0], re1, g_d[4]);
    end
`else
    checks++;
    if (g_d[4] !== 4'h2 || g_d[3] !== 4'h3 || n_cells !== 100) begin
      errors++;
      $display("FAIL range_discard got=%0h %0h %0d want=2 3 100",
               g_d[4], g_d[3], n_cells);
    end
    ram[4] = 32'd4;
`endif
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = i;
    test_reset();
    test_frame();
    test_stall();
    test_start_ignored();
    test_reset_midframe();
    test_latency3();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
